// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Two-road signalised intersection controller with an optional pedestrian
//   walk phase. All phase changes happen on a clock where sec_tick is high.
//   The timer counts seconds spent in the current phase, starting at 1 on entry.
//
// Optional feature macro: TRAFFIC_PED_WALK_EN
//   defined   : ped_req latches a walk request; the WALK phase and walk output are live.
//   undefined : ped_req is ignored, WALK is unreachable, walk is held at 0.
//
// Ports
//   CLK100MHZ   in   system clock
//   CPU_RESETN  in   asynchronous active-low reset
//   sec_tick    in   one-cycle strobe, once per second
//   carA_req    in   vehicle present on road A (level)
//   carB_req    in   vehicle present on road B (level)
//   ped_req     in   pedestrian button (any pulse width)
//   lightA      out  {red,yellow,green} for road A
//   lightB      out  {red,yellow,green} for road B
//   walk        out  pedestrian walk indicator
//   phase       out  current state code
//   timer       out  seconds in current state, saturates at 15
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 5
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       sec_tick,
  input  logic       carA_req,
  input  logic       carB_req,
  input  logic       ped_req,
  output logic [2:0] lightA,
  output logic [2:0] lightB,
  output logic       walk,
  output logic [2:0] phase,
  output logic [3:0] timer
);

  typedef enum logic [2:0] {
    GREEN_A  = 3'd0,
    YELLOW_A = 3'd1,
    RED_A    = 3'd2,
    GREEN_B  = 3'd3,
    YELLOW_B = 3'd4,
    RED_B    = 3'd5,
    WALK     = 3'd6,
    BAD      = 3'd7
  } state_t;

  localparam logic [3:0] MIN_G  = 4'(MIN_GREEN);
  localparam logic [3:0] MAX_G  = 4'(MAX_GREEN);
  localparam logic [3:0] YEL_L  = 4'(YELLOW_T);
  localparam logic [3:0] RED_L  = 4'(ALLRED_T);
  localparam logic [3:0] WALK_L = 4'(WALK_T);

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  state_t     state_reg, state_next;
  logic [3:0] timer_reg, timer_next;
  logic       pend_a_reg, pend_a_next;
  logic       pend_b_reg, pend_b_next;
  logic       pend_p_reg;
  logic       ret_b_reg, ret_b_next;   // 1: WALK returns to GREEN_B, 0: to GREEN_A
  logic       entry;
  logic       green_a_done, green_b_done;
  logic [2:0] light_a_next, light_b_next;

  // A green may only end when the other side (or a pedestrian) is waiting,
  // then either at max green or, after min green, once its own traffic is gone.
  assign green_a_done = (pend_b_reg | pend_p_reg) &&
                        ((timer_reg >= MAX_G) || ((timer_reg >= MIN_G) && !carA_req));
  assign green_b_done = (pend_a_reg | pend_p_reg) &&
                        ((timer_reg >= MAX_G) || ((timer_reg >= MIN_G) && !carB_req));

  always_comb begin
    state_next = state_reg;
    ret_b_next = ret_b_reg;
    case (state_reg)
      GREEN_A:  if (sec_tick && green_a_done) state_next = YELLOW_A;
      YELLOW_A: if (sec_tick && timer_reg >= YEL_L) state_next = RED_A;
      RED_A:    if (sec_tick && timer_reg >= RED_L) begin
                  if (pend_p_reg) begin
                    state_next = WALK;
                    ret_b_next = 1'b1;
                  end else begin
                    state_next = GREEN_B;
                  end
                end
      GREEN_B:  if (sec_tick && green_b_done) state_next = YELLOW_B;
      YELLOW_B: if (sec_tick && timer_reg >= YEL_L) state_next = RED_B;
      RED_B:    if (sec_tick && timer_reg >= RED_L) begin
                  if (pend_p_reg) begin
                    state_next = WALK;
                    ret_b_next = 1'b0;
                  end else begin
                    state_next = GREEN_A;
                  end
                end
`ifdef TRAFFIC_PED_WALK_EN
      WALK:     if (sec_tick && timer_reg >= WALK_L) state_next = ret_b_reg ? GREEN_B : GREEN_A;
`endif
      // Undefined codes recover to RED_B immediately, without waiting for a tick.
      default:  state_next = RED_B;
    endcase
  end

  // Entry is any change of state; the timer restarts at 1 and the request
  // latch served by the new phase is dropped (clear beats a simultaneous set).
  assign entry = (state_next != state_reg);

  always_comb begin
    timer_next = timer_reg;
    if (entry) begin
      timer_next = 4'd1;
    end else if (sec_tick && timer_reg != 4'd15) begin
      timer_next = timer_reg + 4'd1;
    end
  end

  assign pend_a_next = (entry && state_next == GREEN_A) ? 1'b0 : (pend_a_reg | carA_req);
  assign pend_b_next = (entry && state_next == GREEN_B) ? 1'b0 : (pend_b_reg | carB_req);

  always_comb begin
    light_a_next = LIGHT_RED;
    light_b_next = LIGHT_RED;
    if (state_next == GREEN_A)  light_a_next = LIGHT_GRN;
    if (state_next == YELLOW_A) light_a_next = LIGHT_YEL;
    if (state_next == GREEN_B)  light_b_next = LIGHT_GRN;
    if (state_next == YELLOW_B) light_b_next = LIGHT_YEL;
  end

  // Lights are registered from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_reg  <= RED_B;
      timer_reg  <= 4'd1;
      pend_a_reg <= 1'b0;
      pend_b_reg <= 1'b0;
      ret_b_reg  <= 1'b0;
      lightA     <= LIGHT_RED;
      lightB     <= LIGHT_RED;
`ifdef TRAFFIC_PED_WALK_EN
      pend_p_reg <= 1'b0;
      walk       <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      pend_a_reg <= pend_a_next;
      pend_b_reg <= pend_b_next;
      ret_b_reg  <= ret_b_next;
      lightA     <= light_a_next;
      lightB     <= light_b_next;
`ifdef TRAFFIC_PED_WALK_EN
      pend_p_reg <= (entry && state_next == WALK) ? 1'b0 : (pend_p_reg | ped_req);
      walk       <= (state_next == WALK);
`endif
    end
  end

`ifndef TRAFFIC_PED_WALK_EN
  logic unused_ped;
  assign pend_p_reg = 1'b0;
  assign walk       = 1'b0;
  assign unused_ped = ped_req ^ ret_b_reg;
`endif

  assign phase = state_reg;
  assign timer = timer_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: directed scenarios plus a randomized
// run compared cycle by cycle against a phase/elapsed-seconds reference model.
module tb_traffic_phase_scheduler;

  localparam int MING = 4;
  localparam int MAXG = 8;
  localparam int YEL  = 2;
  localparam int AR   = 2;
  localparam int WT   = 5;
`ifdef TRAFFIC_PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       car_a = 1'b0;
  logic       car_b = 1'b0;
  logic       ped = 1'b0;
  logic [2:0] light_a, light_b;
  logic       walk;
  logic [2:0] phase;
  logic [3:0] timer;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_phase, m_time;
  bit m_pa, m_pb, m_pp, m_ret;

  traffic_phase_scheduler #(
    .MIN_GREEN(MING), .MAX_GREEN(MAXG), .YELLOW_T(YEL), .ALLRED_T(AR), .WALK_T(WT)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .sec_tick  (sec_tick),
    .carA_req  (car_a),
    .carB_req  (car_b),
    .ped_req   (ped),
    .lightA    (light_a),
    .lightB    (light_b),
    .walk      (walk),
    .phase     (phase),
    .timer     (timer)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_phase = 5; m_time = 1;
    m_pa = 0; m_pb = 0; m_pp = 0; m_ret = 0;
  endtask

  // One clock of the intersection rules, phrased as phase + elapsed seconds.
  task automatic m_step(input bit tk, input bit a, input bit b, input bit p);
    int  np;
    bit  moved;
    np = m_phase;
    if (tk) begin
      case (m_phase)
        0: if ((m_pb || m_pp) && (m_time >= MAXG || (m_time >= MING && !a))) np = 1;
        1: if (m_time >= YEL) np = 2;
        2: if (m_time >= AR) np = m_pp ? 6 : 3;
        3: if ((m_pa || m_pp) && (m_time >= MAXG || (m_time >= MING && !b))) np = 4;
        4: if (m_time >= YEL) np = 5;
        5: if (m_time >= AR) np = m_pp ? 6 : 0;
        6: if (m_time >= WT) np = m_ret ? 3 : 0;
        default: np = 5;
      endcase
    end
    moved = (np != m_phase);
    if (moved && np == 6) m_ret = (m_phase == 2);
    m_pa = (moved && np == 0) ? 1'b0 : (m_pa | a);
    m_pb = (moved && np == 3) ? 1'b0 : (m_pb | b);
    m_pp = (moved && np == 6) ? 1'b0 : (m_pp | (p & PED));
    if (moved) m_time = 1;
    else if (tk) m_time = m_time + 1;
    m_phase = np;
  endtask

  task automatic cyc(input bit tk, input bit p);
    sec_tick = tk;
    ped = p;
    @(posedge clk);
    m_step(tk, car_a, car_b, p);
    #1;
    sec_tick = 1'b0;
    ped = 1'b0;
  endtask

  task automatic tick();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sec_tick = 1'b0; ped = 1'b0; car_a = 1'b0; car_b = 1'b0;
    #2;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Bring the intersection to GREEN_A with timer 1 from reset.
  task automatic to_green_a();
    do_reset();
    tick();
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (phase !== 3'd5) begin n_fail++; $display("FAIL reset_phase got %0d want 5", phase); end
    n_tests++;
    if (timer !== 4'd1) begin n_fail++; $display("FAIL reset_timer got %0d want 1", timer); end
    n_tests++;
    if (light_a !== 3'b100 || light_b !== 3'b100) begin
      n_fail++; $display("FAIL reset_lights got %b/%b want 100/100", light_a, light_b);
    end
    n_tests++;
    if (walk !== 1'b0) begin n_fail++; $display("FAIL reset_walk got %b want 0", walk); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_idle();
    do_reset();
    tick();
    n_tests++;
    if (phase !== 3'd5 || timer !== 4'd2) begin
      n_fail++; $display("FAIL idle_red_b got phase %0d timer %0d want 5/2", phase, timer);
    end
    tick();
    n_tests++;
    if (phase !== 3'd0 || timer !== 4'd1) begin
      n_fail++; $display("FAIL idle_green_a got phase %0d timer %0d want 0/1", phase, timer);
    end
    for (int i = 0; i < 18; i++) tick();
    n_tests++;
    if (phase !== 3'd0 || timer !== 4'd15) begin
      n_fail++; $display("FAIL idle_saturate got phase %0d timer %0d want 0/15", phase, timer);
    end
    n_tests++;
    if (light_a !== 3'b001 || light_b !== 3'b100) begin
      n_fail++; $display("FAIL idle_lights got %b/%b want 001/100", light_a, light_b);
    end
    $display("[TB] test_idle done");
  endtask

  task automatic test_max_green();
    logic [3:0] pre;
    bit         seen;
    to_green_a();
    tick();
    car_a = 1'b1;
    car_b = 1'b1;
    cyc(1'b0, 1'b0);
    car_b = 1'b0;
    pre = 4'd0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pre = timer;
      tick();
      if (phase != 3'd0) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!seen || phase !== 3'd1 || pre !== 4'd8) begin
      n_fail++; $display("FAIL max_green got phase %0d at timer %0d want 1 at 8", phase, pre);
    end
    n_tests++;
    if (light_a !== 3'b010 || light_b !== 3'b100) begin
      n_fail++; $display("FAIL yellow_lights got %b/%b want 010/100", light_a, light_b);
    end
    tick(); tick();
    n_tests++;
    if (phase !== 3'd2) begin n_fail++; $display("FAIL max_red_a got %0d want 2", phase); end
    tick(); tick();
    n_tests++;
    if (phase !== 3'd3 || light_b !== 3'b001) begin
      n_fail++; $display("FAIL max_green_b got phase %0d lightB %b want 3/001", phase, light_b);
    end
    car_a = 1'b0;
    $display("[TB] test_max_green done");
  endtask

  task automatic test_gap_out();
    logic [3:0] pre;
    bit         seen;
    to_green_a();
    car_b = 1'b1;
    pre = 4'd0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pre = timer;
      tick();
      if (phase != 3'd0) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!seen || phase !== 3'd1 || pre !== 4'd4) begin
      n_fail++; $display("FAIL gap_out got phase %0d at timer %0d want 1 at 4", phase, pre);
    end
    car_b = 1'b0;
    $display("[TB] test_gap_out done");
  endtask

  task automatic test_ped_walk();
    logic [3:0] pre;
    bit         seen;
    int         wticks;
    to_green_a();
    car_b = 1'b1;
    cyc(1'b0, 1'b0);
    car_b = 1'b0;
    for (int i = 0; i < 20 && phase == 3'd0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (phase !== 3'd3) begin n_fail++; $display("FAIL ped_setup got %0d want 3", phase); end
    cyc(1'b0, 1'b1);
`ifdef TRAFFIC_PED_WALK_EN
    pre = 4'd0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pre = timer;
      tick();
      if (phase != 3'd3) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!seen || phase !== 3'd4 || pre !== 4'd4) begin
      n_fail++; $display("FAIL ped_yellow_b got phase %0d at timer %0d want 4 at 4", phase, pre);
    end
    tick(); tick(); tick(); tick();
    n_tests++;
    if (phase !== 3'd6 || walk !== 1'b1) begin
      n_fail++; $display("FAIL ped_walk_entry got phase %0d walk %b want 6/1", phase, walk);
    end
    n_tests++;
    if (light_a !== 3'b100 || light_b !== 3'b100) begin
      n_fail++; $display("FAIL ped_walk_lights got %b/%b want 100/100", light_a, light_b);
    end
    wticks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      wticks++;
      if (phase != 3'd6) break;
    end
    n_tests++;
    if (wticks != 5 || phase !== 3'd0 || walk !== 1'b0) begin
      n_fail++; $display("FAIL ped_walk_len got %0d ticks phase %0d walk %b want 5/0/0", wticks, phase, walk);
    end
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (phase !== 3'd0) begin n_fail++; $display("FAIL ped_cleared got %0d want 0", phase); end
`else
    pre = 4'd0; seen = 1'b0; wticks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (phase == 3'd6) seen = 1'b1;
      if (walk) wticks++;
    end
    n_tests++;
    if (seen || wticks != 0 || phase !== 3'd3 || pre !== 4'd0) begin
      n_fail++; $display("FAIL ped_disabled got walk %0d phase %0d want 0/3", wticks, phase);
    end
`endif
    $display("[TB] test_ped_walk done");
  endtask

  task automatic test_reset_mid_phase();
    to_green_a();
    car_b = 1'b1;
    for (int i = 0; i < 20 && phase == 3'd0; i++) tick();
    n_tests++;
    if (phase !== 3'd1 || timer !== 4'd1) begin
      n_fail++; $display("FAIL mid_setup got phase %0d timer %0d want 1/1", phase, timer);
    end
    cyc(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (phase !== 3'd5 || timer !== 4'd1 || light_a !== 3'b100 || light_b !== 3'b100 || walk !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got phase %0d timer %0d lights %b/%b walk %b want 5/1/100/100/0",
                         phase, timer, light_a, light_b, walk);
    end
    car_b = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(); tick();
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (phase !== 3'd0) begin n_fail++; $display("FAIL mid_pend_cleared got %0d want 0", phase); end
    $display("[TB] test_reset_mid_phase done");
  endtask

  task automatic test_random();
    int exp_la, exp_lb, exp_t;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      if ($urandom_range(0, 19) == 0) car_a = ~car_a;
      if ($urandom_range(0, 19) == 0) car_b = ~car_b;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      exp_la = (m_phase == 0) ? 1 : (m_phase == 1) ? 2 : 4;
      exp_lb = (m_phase == 3) ? 1 : (m_phase == 4) ? 2 : 4;
      exp_t  = (m_time > 15) ? 15 : m_time;
      n_tests++;
      if (phase !== 3'(m_phase) || timer !== 4'(exp_t) || light_a !== 3'(exp_la) ||
          light_b !== 3'(exp_lb) || walk !== (m_phase == 6)) begin
        n_fail++;
        $display("FAIL random cyc %0d got ph %0d t %0d la %b lb %b w %b want ph %0d t %0d la %b lb %b w %b",
                 i, phase, timer, light_a, light_b, walk,
                 m_phase, exp_t, 3'(exp_la), 3'(exp_lb), m_phase == 6);
      end
      n_tests++;
      if (light_a !== 3'b100 && light_b !== 3'b100) begin
        n_fail++; $display("FAIL random_conflict cyc %0d got %b/%b want one road red", i, light_a, light_b);
      end
    end
    car_a = 1'b0; car_b = 1'b0;
    $display("[TB] test_random done");
  endtask

  initial begin
    m_reset();
    test_reset();
    test_idle();
    test_max_green();
    test_gap_out();
    test_ped_walk();
    test_reset_mid_phase();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter MIN_GREEN, default 4, minimum green seconds per road.
REQ-002 Parameter MAX_GREEN, default 8, maximum green seconds per road when a competing request is pending.
REQ-003 Parameter YELLOW_T, default 2, yellow seconds.
REQ-004 Parameter ALLRED_T, default 2, all-red clearance seconds.
REQ-005 Parameter WALK_T, default 5, pedestrian walk seconds.
REQ-006 Port CLK100MHZ, input, 1, the single system clock; reset is asynchronous and active-low.
REQ-007 Port CPU_RESETN, input, 1, asynchronous active-low reset.
REQ-008 Port sec_tick, input, 1, one-cycle strobe, once per second.
REQ-009 Port carA_req / carB_req, input, 1 each, vehicle-present level for road A / road B.
REQ-010 Port ped_req, input, 1, pedestrian button, any width pulse.
REQ-011 Port lightA / lightB, output, 3 each, {red,yellow,green} one-hot for road A / road B.
REQ-012 Port walk, output, 1, pedestrian walk indicator.
REQ-013 Port phase, output, 3, encoded current state; timer, output, 4, seconds in current state.

Function
REQ-014 States SHALL be GREEN_A=0, YELLOW_A=1, RED_A=2, GREEN_B=3, YELLOW_B=4, RED_B=5, WALK=6; code 7 SHALL go to RED_B with the timer loaded to 1 on the next clock.
REQ-015 Timer SHALL load 1 on every state entry, increment on sec_tick otherwise, and saturate at 15.
REQ-016 Every transition SHALL occur only on a clock with sec_tick=1; the state, timer and outputs update at that clock edge.
REQ-017 Pending latches pendA, pendB and pendP SHALL set while carA_req, carB_req and ped_req are high, respectively.
REQ-018 pendA SHALL clear on entry to GREEN_A, pendB on entry to GREEN_B, and pendP on entry to WALK; clear wins over a simultaneous set.
REQ-019 Competing request for GREEN_A: pendB|pendP. Competing request for GREEN_B: pendA|pendP.
REQ-020 GREEN_x to YELLOW_x SHALL occur when a competing request is pending and either (timer>=MAX_GREEN) or (timer>=MIN_GREEN and carx_req=0).
REQ-021 GREEN_x SHALL hold indefinitely if no competing request is pending.
REQ-022 YELLOW_x to RED_x SHALL occur when timer>=YELLOW_T.
REQ-023 RED_x SHALL move when timer>=ALLRED_T: to WALK if pendP, else to the green of the other road.
REQ-024 WALK to green SHALL occur when timer>=WALK_T; the target is GREEN_B if WALK was entered from RED_A and GREEN_A if it was entered from RED_B, held in a 1-bit register.
REQ-025 lightA SHALL be green in GREEN_A, yellow in YELLOW_A, and red in all other states.
REQ-026 lightB SHALL be green in GREEN_B, yellow in YELLOW_B, and red in all other states.
REQ-027 walk SHALL be 1 only in WALK.
REQ-028 All outputs SHALL be registered, Moore, and decoded from the state register and timer.
REQ-029 Red SHALL never coexist with green or yellow on the same road.
REQ-030 Both roads SHALL never be non-red at the same time.

Reset
REQ-031 CPU_RESETN low SHALL asynchronously force: state=RED_B, timer=1, pendA=pendB=pendP=0, walk-return bit=0, lightA=lightB=3'b100, walk=0, phase=5.
REQ-032 After CPU_RESETN deasserts, the first transition SHALL be RED_B to GREEN_A after ALLRED_T ticks, or to WALK if a ped request arrived in the meantime.
REQ-033 Reset asserted mid-phase SHALL abandon the phase with no intermediate yellow.

Configuration
REQ-034 Macro TRAFFIC_PED_WALK_EN defined: pendP, the WALK state and the walk output SHALL behave as specified above.
REQ-035 Macro TRAFFIC_PED_WALK_EN undefined: pendP SHALL be constant 0, WALK SHALL be unreachable (code 6 handled like code 7), walk SHALL be tied to 0, and ped_req SHALL be ignored.

Verification
REQ-036 Reset, no requests, 20 ticks -> RED_B for 2 ticks, then GREEN_A held, timer saturates at 15, lightA=001, lightB=100.
REQ-037 In GREEN_A timer=2, carA_req=1 held, carB pulse -> YELLOW_A on the tick where timer>=8; RED_A after 2 ticks; GREEN_B after 2 more ticks.
REQ-038 In GREEN_A with carA_req=0 and carB_req=1 -> YELLOW_A on the tick where timer>=4 (gap-out).
REQ-039 ped_req pulse during GREEN_B (macro on) -> YELLOW_B at timer 4 (carB=0), RED_B, WALK with walk=1 for 5 ticks, then GREEN_A; pendP cleared.
REQ-040 Same stimulus as REQ-039 with the macro off -> the sequence never enters WALK, walk stays 0, and GREEN_B holds.
REQ-041 CPU_RESETN pulsed low during YELLOW_A with timer=1 -> immediate phase=5, lights 100/100, pend latches cleared.
